// File: rtl/wb_initiator_pkg.sv
// Shared constants for the Wishbone initiator: FSM state codes, response
// status codes and the width of the transfer timeout counter.
package wb_initiator_pkg;

    // Width of the cycle counter used to abort unanswered transfers.
    localparam int TIMER_WIDTH = 16;

    // FSM state codes, kept as plain constants so legacy blocks can share them.
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_REQ     = 3'd1;
    localparam state_t ST_WAIT    = 3'd2;
    localparam state_t ST_BACKOFF = 3'd3;
    localparam state_t ST_RESP    = 3'd4;

    // Response status codes reported on rsp_status_o.
    typedef enum logic [1:0] {
        STATUS_OK              = 2'b00,
        STATUS_ERR             = 2'b01,
        STATUS_RETRY_EXHAUSTED = 2'b10,
        STATUS_TIMEOUT         = 2'b11
    } status_t;

endpackage

// File: rtl/wb_initiator_timer.sv
// Transfer timeout counter: counts enabled cycles since the last clear and
// flags when TIMEOUT cycles have elapsed without a bus termination.
module wb_initiator_timer
    import wb_initiator_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TIMER_WIDTH-1:0] count;

    assign expired = (count == TIMER_WIDTH'(TIMEOUT));

    // Count waiting cycles; hold once expired so the flag stays up until cleared.
    always_ff @(posedge clk_i) begin
        // NOTE: state held across clock edges is always written with <=, so every
        // flop samples the values from before the edge regardless of block order.
        if (rst_i) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/wb_initiator.sv
// Single-outstanding Wishbone initiator: accepts one command, runs it on the
// bus with retry and timeout handling, and returns one response.
module wb_initiator
    import wb_initiator_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int TIMEOUT    = 255,
    parameter int MAX_RETRY  = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_we_i,
    input  logic [ADDR_WIDTH-3:0] cmd_adr_i,
    input  logic [3:0]            cmd_sel_i,
    input  logic [31:0]           cmd_dat_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [31:0]           rsp_dat_o,
    output logic [1:0]            rsp_status_o,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic [ADDR_WIDTH-3:0] wb_adr_o,
    output logic [3:0]            wb_sel_o,
    output logic                  wb_we_o,
    output logic [31:0]           wb_dat_o,
    input  logic                  wb_ack_i,
    input  logic                  wb_err_i,
    input  logic                  wb_rty_i,
    input  logic                  wb_stall_i,
    input  logic [31:0]           wb_dat_i
);

    state_t      state;
    state_t      next_state;
    logic [3:0]  retry_cnt;
    logic        cmd_accept;
    logic        term_active;
    logic        term_seen;
    logic        retry_inc;
    logic        capture_rsp;
    logic [1:0]  next_status;
    logic [31:0] next_dat;
    logic        timer_clear;
    logic        timer_enable;
    logic        timer_expired;

    // Ready is the only combinational output; it stays low while reset is held.
    assign cmd_ready_o = (state == ST_IDLE) && !rst_i;
    assign cmd_accept  = (state == ST_IDLE) && cmd_valid_i;

    // Terminations count in WAIT, or in REQ once the slave has taken the strobe.
    assign term_active = (state == ST_WAIT) || ((state == ST_REQ) && !wb_stall_i);
    assign term_seen   = term_active && (wb_ack_i || wb_err_i || wb_rty_i);

    assign timer_clear  = (next_state == ST_REQ) && (state != ST_REQ);
    assign timer_enable = ((state == ST_REQ) || (state == ST_WAIT)) && !term_seen;

    wb_initiator_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    // Next-state and response selection; err beats rty beats ack beats timeout.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can
        // leave one unassigned and turn it into a latch.
        next_state  = state;
        capture_rsp = 1'b0;
        retry_inc   = 1'b0;
        next_status = STATUS_OK;
        next_dat    = '0;
        case (state)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    next_state = ST_REQ;
                end
            end
            ST_REQ, ST_WAIT: begin
                if (term_active && wb_err_i) begin
                    next_state  = ST_RESP;
                    capture_rsp = 1'b1;
                    next_status = STATUS_ERR;
                end else if (term_active && wb_rty_i) begin
                    if (retry_cnt < 4'(MAX_RETRY)) begin
                        next_state = ST_BACKOFF;
                        retry_inc  = 1'b1;
                    end else begin
                        next_state  = ST_RESP;
                        capture_rsp = 1'b1;
                        next_status = STATUS_RETRY_EXHAUSTED;
                    end
                end else if (term_active && wb_ack_i) begin
                    next_state  = ST_RESP;
                    capture_rsp = 1'b1;
                    next_status = STATUS_OK;
                    next_dat    = wb_we_o ? 32'd0 : wb_dat_i;
                end else if (timer_expired) begin
                    next_state  = ST_RESP;
                    capture_rsp = 1'b1;
                    next_status = STATUS_TIMEOUT;
                end else if ((state == ST_REQ) && !wb_stall_i) begin
                    next_state = ST_WAIT;
                end
            end
            ST_BACKOFF: begin
                next_state = ST_REQ;
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Registered cycle/strobe, decoded from the state being entered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
        end else begin
            wb_cyc_o <= (next_state == ST_REQ) || (next_state == ST_WAIT);
            wb_stb_o <= (next_state == ST_REQ);
        end
    end

    // Command registers double as the bus address/data outputs; loaded only on accept.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wb_adr_o <= '0;
            wb_sel_o <= '0;
            wb_we_o  <= 1'b0;
            wb_dat_o <= '0;
        end else if (cmd_accept) begin
            wb_adr_o <= cmd_adr_i;
            wb_sel_o <= cmd_sel_i;
            wb_we_o  <= cmd_we_i;
            wb_dat_o <= cmd_dat_i;
        end
    end

    // Retry counter: restarts with each command, steps on every honoured retry.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            retry_cnt <= '0;
        end else if (cmd_accept) begin
            retry_cnt <= '0;
        end else if (retry_inc) begin
            retry_cnt <= retry_cnt + 1'b1;
        end
    end

    // Response registers: captured on termination, held through RESP.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_valid_o  <= 1'b0;
            rsp_dat_o    <= '0;
            rsp_status_o <= STATUS_OK;
        end else begin
            rsp_valid_o <= (next_state == ST_RESP);
            if (capture_rsp) begin
                rsp_dat_o    <= next_dat;
                rsp_status_o <= next_status;
            end
        end
    end

endmodule
